// File: rtl/seq_pkg.sv
// seq_pkg: shared types, illegal-code constants and successor/membership helpers
// for the 0->5->7->6->3->2->0 sequence.
package seq_pkg;
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} seq_state_t;
    localparam logic [2:0] SEQ_ILLEGAL_A = 3'd1;
    localparam logic [2:0] SEQ_ILLEGAL_B = 3'd4;
    function automatic logic [2:0] seq_succ(input logic [2:0] c);
        case (c)
            3'd0:    seq_succ = 3'd5;
            3'd5:    seq_succ = 3'd7;
            3'd7:    seq_succ = 3'd6;
            3'd6:    seq_succ = 3'd3;
            3'd3:    seq_succ = 3'd2;
            default: seq_succ = 3'd0;
        endcase
    endfunction
    function automatic logic seq_is_member(input logic [2:0] c);
        return !(c == SEQ_ILLEGAL_A || c == SEQ_ILLEGAL_B);
    endfunction
endpackage

// File: rtl/seq_next_lut.sv
// seq_next_lut: combinational successor lookup and membership test for one code.
//   i_code   in  3  code to look up
//   o_succ   out 3  next code in the sequence (0 for illegal codes)
//   o_member out 1  high when i_code is one of {0,2,3,5,6,7}
module seq_next_lut
    import seq_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [2:0] o_succ,
    output logic       o_member
);
    assign o_succ   = seq_succ(i_code);
    assign o_member = seq_is_member(i_code);
endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: receive-side lock/flywheel checker for the 3-bit sequence code.
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   in_valid  in  1      qualifies in_q
//   in_q      in  3      received code
//   locked    out 1      FSM is in LOCKED
//   err       out 1      pulse: mismatch while LOCKED
//   illegal   out 1      pulse: sampled code is 1 or 4
//   expected  out 3      code expected on the next valid sample
//   err_count out ERR_W  saturating count of LOCKED mismatches
module sequence_checker
    import seq_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_q,
    output logic             locked,
    output logic             err,
    output logic             illegal,
    output logic [2:0]       expected,
    output logic [ERR_W-1:0] err_count
);
    localparam int CW = $clog2((LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT) + 1);
    seq_state_t       r_state, w_state;
    logic [2:0]       r_exp, w_exp;
    logic [CW-1:0]    r_match, w_match, r_miss, w_miss;
    logic             r_err, w_err, r_ill, w_ill;
    logic [ERR_W-1:0] r_cnt, w_cnt;
    logic [2:0]       w_in_succ, w_exp_succ;
    logic             w_in_member, w_exp_member;
    logic [CW-1:0]    w_match_inc, w_miss_inc;
    seq_next_lut u_lut_in  (.i_code(in_q),  .o_succ(w_in_succ),  .o_member(w_in_member));
    seq_next_lut u_lut_exp (.i_code(r_exp), .o_succ(w_exp_succ), .o_member(w_exp_member));
    assign w_match_inc = r_match + CW'(1);
    assign w_miss_inc  = r_miss + CW'(1);
    always_comb begin
        w_state = r_state;
        w_exp   = r_exp;
        w_match = r_match;
        w_miss  = r_miss;
        w_err   = 1'b0;
        w_ill   = 1'b0;
        w_cnt   = r_cnt;
        if (in_valid) begin
            w_ill = !w_in_member;
            case (r_state)
                LOCKED: begin
                    // Flywheel: advance regardless of the symbol; an illegal
                    // expected value (never reached normally) resyncs to the input.
                    w_exp = w_exp_member ? w_exp_succ : w_in_succ;
                    if (in_q == r_exp) begin
                        w_miss = '0;
                    end else begin
                        w_err = 1'b1;
                        w_cnt = &r_cnt ? r_cnt : r_cnt + ERR_W'(1);
                        w_miss = w_miss_inc;
                        if (w_miss_inc == CW'(LOSS_CNT)) begin
                            w_state = HUNT;
                            w_miss  = '0;
                            w_match = '0;
                        end
                    end
                end
                SYNC: begin
                    if (in_q == r_exp) begin
                        w_match = w_match_inc;
                        w_exp   = w_in_succ;
                        w_state = (w_match_inc == CW'(LOCK_CNT)) ? LOCKED : SYNC;
                    end else if (w_in_member) begin
                        w_match = CW'(1);
                        w_exp   = w_in_succ;
                    end else begin
                        w_state = HUNT;
                        w_match = '0;
                    end
                end
                default: begin
                    if (w_in_member) begin
                        w_match = CW'(1);
                        w_exp   = w_in_succ;
                        w_state = (LOCK_CNT == 1) ? LOCKED : SYNC;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
            r_exp   <= 3'd0;
            r_match <= '0;
            r_miss  <= '0;
            r_err   <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_exp   <= w_exp;
            r_match <= w_match;
            r_miss  <= w_miss;
            r_err   <= w_err;
            r_ill   <= w_ill;
            r_cnt   <= w_cnt;
        end
    end
    assign locked    = (r_state == LOCKED);
    assign err       = r_err;
    assign illegal   = r_ill;
    assign expected  = r_exp;
    assign err_count = r_cnt;
endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: scoreboard bench with directed and random stimulus against a sequence-position model.
module tb_sequence_checker;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int ERR_W    = 8;
    localparam int CNT_MAX  = (1 << ERR_W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [2:0] in_q = 3'd0;
    logic locked, err, illegal;
    logic [2:0] expected;
    logic [ERR_W-1:0] err_count;
    sequence_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_q(in_q),
        .locked(locked), .err(err), .illegal(illegal),
        .expected(expected), .err_count(err_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic       locked;
        logic       err;
        logic       ill;
        logic [2:0] exp;
        int         cnt;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int seq_codes[6] = '{0, 5, 7, 6, 3, 2};
    // model: 0=searching, 1=acquiring, 2=tracking
    int m_mode = 0, m_exp = 0, m_good = 0, m_bad = 0, m_cnt = 0;
    bit m_err = 0, m_ill = 0;
    function automatic int pos_of(int c);
        for (int i = 0; i < 6; i++) if (seq_codes[i] == c) return i;
        return -1;
    endfunction
    function automatic int after(int c);
        return seq_codes[(pos_of(c) + 1) % 6];
    endfunction
    task automatic model_step(input bit r, input bit v, input int q);
        if (r) begin
            m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_err = 0; m_ill = 0;
            return;
        end
        m_err = 0;
        m_ill = 0;
        if (!v) return;
        m_ill = pos_of(q) < 0;
        if (m_mode == 2) begin
            if (q == m_exp) m_bad = 0;
            else begin
                m_err = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_bad++;
                if (m_bad >= LOSS_CNT) begin
                    m_mode = 0; m_bad = 0; m_good = 0;
                end
            end
            if (m_mode == 2 || m_err) m_exp = after(m_exp);
        end else if (pos_of(q) >= 0) begin
            m_good = (m_mode == 1 && q == m_exp) ? m_good + 1 : 1;
            m_exp = after(q);
            m_mode = (m_good >= LOCK_CNT) ? 2 : 1;
        end else begin
            m_mode = 0;
            m_good = 0;
        end
    endtask
    task automatic apply(input bit r, input bit v, input int q);
        exp_t e;
        @(negedge clk);
        rst = r;
        in_valid = v;
        in_q = 3'(q);
        model_step(r, v, q);
        e.locked = (m_mode == 2);
        e.err = m_err;
        e.ill = m_ill;
        e.exp = 3'(m_exp);
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask
    task automatic feed(input int q);
        apply(0, 1, q);
    endtask
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (locked !== e.locked) begin miscompares++; $display("FAIL locked: got %b want %b at %0t", locked, e.locked, $time); end
            if (err !== e.err) begin miscompares++; $display("FAIL err: got %b want %b at %0t", err, e.err, $time); end
            if (illegal !== e.ill) begin miscompares++; $display("FAIL illegal: got %b want %b at %0t", illegal, e.ill, $time); end
            if (expected !== e.exp) begin miscompares++; $display("FAIL expected: got %0d want %0d at %0t", expected, e.exp, $time); end
            if (err_count !== ERR_W'(e.cnt)) begin miscompares++; $display("FAIL err_count: got %0d want %0d at %0t", err_count, e.cnt, $time); end
        end
    end
    initial begin
        int q;
        int budget;
        apply(1, 0, 0);
        apply(1, 0, 0);
        apply(0, 0, 0);
        apply(0, 0, 0);
        foreach (seq_codes[i]) feed(seq_codes[i]);
        feed(0);
        feed(5); feed(7); feed(6); feed(3); feed(4); feed(0);
        feed(5); feed(7); feed(2); feed(2);
        apply(0, 0, 0);
        feed(0); feed(5); feed(3); feed(2); feed(0);
        feed(2); feed(2);
        for (int k = 0; k < 130; k++) begin
            feed(0); feed(5); feed(7); feed(2); feed(2);
        end
        feed(0); feed(5); feed(7); feed(2);
        apply(1, 1, 6);
        apply(0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            q = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : m_exp;
            apply($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, q);
        end
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
